// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS execute stage: ALUOp codes, funct values,
// control-bundle bit positions and the internal ALU operation enum.
package mips_pkg;

  localparam int DATA_W = 32;
  localparam int WB_W   = 2;
  localparam int MEM_W  = 3;
  localparam int EX_W   = 4;

  // EX control bundle is {RegDst, ALUOp[1:0], ALUSrc}
  localparam int EX_REGDST    = 3;
  localparam int EX_ALUOP_MSB = 2;
  localparam int EX_ALUOP_LSB = 1;
  localparam int EX_ALUSRC    = 0;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [5:0] FUNCT_ADD   = 6'h20;
  localparam logic [5:0] FUNCT_SUB   = 6'h22;
  localparam logic [5:0] FUNCT_AND   = 6'h24;
  localparam logic [5:0] FUNCT_OR    = 6'h25;
  localparam logic [5:0] FUNCT_NOR   = 6'h27;
  localparam logic [5:0] FUNCT_SLT   = 6'h2A;
  localparam logic [5:0] FUNCT_MFHI  = 6'h10;
  localparam logic [5:0] FUNCT_MFLO  = 6'h12;
  localparam logic [5:0] FUNCT_MULT  = 6'h18;
  localparam logic [5:0] FUNCT_MULTU = 6'h19;
  localparam logic [5:0] FUNCT_DIV   = 6'h1A;
  localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

  typedef enum logic [3:0] {
    ALU_NONE,
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_NOR,
    ALU_SLT,
    ALU_MFHI,
    ALU_MFLO,
    ALU_MULDIV
  } alu_op_e;

  // Mult/div operation code; equals funct[1:0] of the mult/div instructions
  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_RUN  = 1'b1
  } md_state_e;

  // Map ALUOp/funct to the internal operation; unknown codes produce ALU_NONE
  function automatic alu_op_e alu_decode(input logic [1:0] aluop, input logic [5:0] funct);
    alu_op_e op;
    op = ALU_NONE;
    case (aluop)
      ALUOP_ADD: op = ALU_ADD;
      ALUOP_SUB: op = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FUNCT_ADD:  op = ALU_ADD;
          FUNCT_SUB:  op = ALU_SUB;
          FUNCT_AND:  op = ALU_AND;
          FUNCT_OR:   op = ALU_OR;
          FUNCT_NOR:  op = ALU_NOR;
          FUNCT_SLT:  op = ALU_SLT;
          FUNCT_MFHI: op = ALU_MFHI;
          FUNCT_MFLO: op = ALU_MFLO;
          FUNCT_MULT, FUNCT_MULTU, FUNCT_DIV, FUNCT_DIVU: op = ALU_MULDIV;
          default:    op = ALU_NONE;
        endcase
      end
      default: op = ALU_NONE;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/ex_muldiv.sv
// Iterative multiply/divide unit with HI/LO. One shift-add (mult) or
// restoring-subtract (div) step per cycle on operand magnitudes; signs are
// applied when the last step is written into HI/LO. busy is the state.
module ex_muldiv
  import mips_pkg::*;
#(
  parameter int          MD_CYCLES = 32,        // must equal DATA_W
  parameter logic [31:0] HILO_RST  = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int CNT_W = $clog2(MD_CYCLES + 1);

  md_state_e        r_state;
  md_state_e        w_state_nx;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_acc;     // mult: upper product half; div: partial remainder
  logic [31:0]      r_q;       // mult: multiplier/lower half; div: dividend/quotient
  logic [31:0]      r_b;       // mult: multiplicand; div: divisor (magnitudes)
  logic [31:0]      r_hi;
  logic [31:0]      r_lo;
  logic             r_is_div;
  logic             r_neg_q;   // negate product / quotient at completion
  logic             r_neg_r;   // negate remainder at completion

  logic             w_is_div;
  logic             w_signed;
  logic             w_a_neg;
  logic             w_b_neg;
  logic [31:0]      w_a_mag;
  logic [31:0]      w_b_mag;
  logic             w_last;
  logic [32:0]      w_sum;
  logic [32:0]      w_shift;
  logic [33:0]      w_diff;
  logic             w_ge;
  logic [31:0]      w_acc_nx;
  logic [31:0]      w_q_nx;
  logic [63:0]      w_prod;
  logic [63:0]      w_prod_fix;
  logic [31:0]      w_hi_fix;
  logic [31:0]      w_lo_fix;

  // Operand conditioning: classify the op and take magnitudes for signed ops
  always_comb begin
    w_is_div = (op == MD_DIV) || (op == MD_DIVU);
    w_signed = (op == MD_MULT) || (op == MD_DIV);
    w_a_neg  = w_signed & a[31];
    w_b_neg  = w_signed & b[31];
    w_a_mag  = w_a_neg ? (32'd0 - a) : a;
    w_b_mag  = w_b_neg ? (32'd0 - b) : b;
  end

  // Next-state: start launches a run, the step that empties the counter ends it
  always_comb begin
    w_state_nx = r_state;
    w_last     = (r_cnt == CNT_W'(1));
    case (r_state)
      MD_IDLE: if (start) w_state_nx = MD_RUN;
      MD_RUN:  if (w_last) w_state_nx = MD_IDLE;
      default: w_state_nx = MD_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= MD_IDLE;
    else      r_state <= w_state_nx;
  end

  // One iteration: shift-add for mult, restoring subtract for div
  always_comb begin
    w_sum    = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_b} : 33'd0);
    w_shift  = {r_acc, r_q[31]};
    w_diff   = {1'b0, w_shift} - {2'b00, r_b};
    w_ge     = ~w_diff[33];
    w_acc_nx = w_sum[32:1];
    w_q_nx   = {w_sum[0], r_q[31:1]};
    if (r_is_div) begin
      w_acc_nx = w_ge ? w_diff[31:0] : w_shift[31:0];
      w_q_nx   = {r_q[30:0], w_ge};
    end
  end

  // Sign fix-up applied to the final iteration's values
  always_comb begin
    w_prod     = {w_acc_nx, w_q_nx};
    w_prod_fix = r_neg_q ? (64'd0 - w_prod) : w_prod;
    w_hi_fix   = w_prod_fix[63:32];
    w_lo_fix   = w_prod_fix[31:0];
    if (r_is_div) begin
      w_lo_fix = r_neg_q ? (32'd0 - w_q_nx)   : w_q_nx;
      w_hi_fix = r_neg_r ? (32'd0 - w_acc_nx) : w_acc_nx;
    end
  end

  // Datapath: latch operands on start, iterate while running, write HI/LO at the end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt    <= '0;
      r_acc    <= '0;
      r_q      <= '0;
      r_b      <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_hi     <= HILO_RST;
      r_lo     <= HILO_RST;
    end else if (r_state == MD_IDLE) begin
      if (start) begin
        r_cnt    <= CNT_W'(MD_CYCLES);
        r_acc    <= '0;
        r_is_div <= w_is_div;
        r_neg_q  <= w_a_neg ^ w_b_neg;
        r_neg_r  <= w_a_neg;
        r_q      <= w_is_div ? w_a_mag : w_b_mag;
        r_b      <= w_is_div ? w_b_mag : w_a_mag;
      end
    end else begin
      r_cnt <= r_cnt - CNT_W'(1);
      r_acc <= w_acc_nx;
      r_q   <= w_q_nx;
      if (w_last) begin
        r_hi <= w_hi_fix;
        r_lo <= w_lo_fix;
      end
    end
  end

  assign busy = (r_state == MD_RUN);
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: rtl/top_ex.sv
// MIPS execute stage: operand select, ALU, destination select, branch target,
// HI/LO access through ex_muldiv, and the EX/MEM pipeline register.
// Interlock: while the mult/div unit is busy, any valid instruction that
// touches HI/LO raises stall; the slot then retires as a bubble and upstream
// holds its inputs until stall drops.
module top_ex
  import mips_pkg::*;
#(
  parameter int          MD_CYCLES = 32,
  parameter logic [31:0] HILO_RST  = 32'h0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               valid,
  input  logic [WB_W-1:0]    WB,
  input  logic [MEM_W-1:0]   MEM,
  input  logic [EX_W-1:0]    EX,
  input  logic [DATA_W-1:0]  pc_plus4,
  input  logic [DATA_W-1:0]  read_data1,
  input  logic [DATA_W-1:0]  read_data2,
  input  logic [DATA_W-1:0]  sign_ext,
  input  logic [4:0]         rt,
  input  logic [4:0]         rd,
  output logic               stall,
  output logic [WB_W-1:0]    WB_out,
  output logic [MEM_W-1:0]   MEM_out,
  output logic               zero,
  output logic [DATA_W-1:0]  result,
  output logic [DATA_W-1:0]  write_data,
  output logic [4:0]         write_register,
  output logic [DATA_W-1:0]  branch_target
);

  logic [1:0]        w_aluop;
  logic [5:0]        w_funct;
  alu_op_e           w_op;
  logic [DATA_W-1:0] w_opb;
  logic [DATA_W-1:0] w_alu;
  logic              w_hilo_user;
  logic              w_md_start;
  logic              w_pass;
  logic              w_busy;
  logic [DATA_W-1:0] w_hi;
  logic [DATA_W-1:0] w_lo;

  logic [WB_W-1:0]   r_wb;
  logic [MEM_W-1:0]  r_mem;
  logic              r_zero;
  logic [DATA_W-1:0] r_result;
  logic [DATA_W-1:0] r_wdata;
  logic [4:0]        r_wreg;
  logic [DATA_W-1:0] r_bt;

  // Decode, interlock and issue qualification
  always_comb begin
    w_aluop     = EX[EX_ALUOP_MSB:EX_ALUOP_LSB];
    w_funct     = sign_ext[5:0];
    w_op        = alu_decode(w_aluop, w_funct);
    w_opb       = EX[EX_ALUSRC] ? sign_ext : read_data2;
    w_hilo_user = (w_op == ALU_MFHI) || (w_op == ALU_MFLO) || (w_op == ALU_MULDIV);
    stall       = w_busy & valid & w_hilo_user;
    w_md_start  = valid & (w_op == ALU_MULDIV) & ~stall;
    // mult/div retire as bubbles; their architectural effect is in HI/LO only
    w_pass      = valid & (w_op != ALU_MULDIV);
  end

  // ALU: wrapping add/sub, logic ops, signed slt, HI/LO moves; others yield 0
  always_comb begin
    w_alu = '0;
    case (w_op)
      ALU_ADD:  w_alu = read_data1 + w_opb;
      ALU_SUB:  w_alu = read_data1 - w_opb;
      ALU_AND:  w_alu = read_data1 & w_opb;
      ALU_OR:   w_alu = read_data1 | w_opb;
      ALU_NOR:  w_alu = ~(read_data1 | w_opb);
      ALU_SLT:  w_alu = {31'd0, ($signed(read_data1) < $signed(w_opb))};
      ALU_MFHI: w_alu = w_hi;
      ALU_MFLO: w_alu = w_lo;
      default:  w_alu = '0;
    endcase
  end

  // mult/div always take rs and rt, independent of ALUSrc; op is funct[1:0]
  ex_muldiv #(
    .MD_CYCLES (MD_CYCLES),
    .HILO_RST  (HILO_RST)
  ) u_muldiv (
    .clk   (clk),
    .rst   (rst),
    .start (w_md_start),
    .op    (w_funct[1:0]),
    .a     (read_data1),
    .b     (read_data2),
    .busy  (w_busy),
    .hi    (w_hi),
    .lo    (w_lo)
  );

  // EX/MEM register: bubble on stall (data held), otherwise capture this slot
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wb     <= '0;
      r_mem    <= '0;
      r_zero   <= 1'b0;
      r_result <= '0;
      r_wdata  <= '0;
      r_wreg   <= '0;
      r_bt     <= '0;
    end else if (stall) begin
      r_wb  <= '0;
      r_mem <= '0;
    end else begin
      r_wb     <= w_pass ? WB  : '0;
      r_mem    <= w_pass ? MEM : '0;
      r_zero   <= (w_alu == '0);
      r_result <= w_alu;
      r_wdata  <= read_data2;
      r_wreg   <= EX[EX_REGDST] ? rd : rt;
      r_bt     <= pc_plus4 + {sign_ext[DATA_W-3:0], 2'b00};
    end
  end

  assign WB_out         = r_wb;
  assign MEM_out        = r_mem;
  assign zero           = r_zero;
  assign result         = r_result;
  assign write_data     = r_wdata;
  assign write_register = r_wreg;
  assign branch_target  = r_bt;

endmodule
